lut_neuron_loader: RTL and testbench

- Runtime-reprogrammable LogicNets neuron. Receives a neuron truth table over a valid/ready configuration stream and writes it into a distributed-RAM LUT.
- Once loaded, serves lookups with a registered 1-cycle latency.
- This is the write side for the fixed-ROM neuron lookups: the same per-neuron truth tables can be loaded at runtime instead of synthesised as constant case ROMs.

---
 rtl/lut_neuron_loader_if.sv | 25 ++
 rtl/lut_neuron_loader.sv | 79 +++++++
 tb/tb_lut_neuron_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/lut_neuron_loader_if.sv
// lut_neuron_loader_if: configuration stream and lookup port bundle for the loadable LUT neuron.
interface lut_neuron_loader_if #(
   parameter int IN_BITS    = 6,
   parameter int OUT_BITS   = 1,
   parameter int LOAD_WIDTH = 8
);
   logic                  cfg_start;
   logic [LOAD_WIDTH-1:0] cfg_data;
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic                  cfg_done;
   logic                  table_loaded;
   logic [IN_BITS-1:0]    in_data;
   logic                  in_valid;
   logic [OUT_BITS-1:0]   out_data;
   logic                  out_valid;
   modport master (
      output cfg_start, cfg_data, cfg_valid, in_data, in_valid,
      input  cfg_ready, cfg_done, table_loaded, out_data, out_valid
   );
   modport slave (
      input  cfg_start, cfg_data, cfg_valid, in_data, in_valid,
      output cfg_ready, cfg_done, table_loaded, out_data, out_valid
   );
endinterface

// File: rtl/lut_neuron_loader.sv
// lut_neuron_loader: streams a neuron truth table into a LUT and serves registered lookups.
module lut_neuron_loader #(
   parameter int IN_BITS    = 6,
   parameter int OUT_BITS   = 1,
   parameter int LOAD_WIDTH = 8
) (
   input logic clk,
   input logic rst,
   lut_neuron_loader_if.slave bus
);
   localparam int DEPTH = 2**IN_BITS;
   localparam int BITS  = DEPTH*OUT_BITS;
   localparam int BEATS = BITS/LOAD_WIDTH;
   localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
   typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;
   state_t                state;
   logic [CW-1:0]         cnt;
   logic [LOAD_WIDTH-1:0] tbl [BEATS];
   logic [BITS-1:0]       flat;
   logic [OUT_BITS-1:0]   ent [DEPTH];
   logic                  accept;
   logic                  last;
   if (BITS % LOAD_WIDTH != 0) begin : g_chk
      $error("LUT size must be a whole number of configuration beats");
   end
   for (genvar k = 0; k < BEATS; k++) begin : g_beat
      assign flat[k*LOAD_WIDTH +: LOAD_WIDTH] = tbl[k];
   end
   for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      assign ent[e] = flat[e*OUT_BITS +: OUT_BITS];
   end
   // a restart in the same cycle discards the presented beat
   always_comb begin
      accept = state == LOAD && bus.cfg_valid && !bus.cfg_start;
      last   = cnt == CW'(BEATS-1);
   end
   always_ff @(posedge clk) begin
      if (accept) tbl[cnt] <= bus.cfg_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= EMPTY;
         cnt              <= '0;
         bus.cfg_ready    <= 1'b0;
         bus.cfg_done     <= 1'b0;
         bus.table_loaded <= 1'b0;
         bus.out_valid    <= 1'b0;
         bus.out_data     <= '0;
      end else begin
         bus.cfg_done  <= 1'b0;
         bus.out_valid <= state == RUN && bus.in_valid;
         if (state == RUN && bus.in_valid) bus.out_data <= ent[bus.in_data];
         case (state)
            EMPTY: if (bus.cfg_start) begin
               state         <= LOAD;
               cnt           <= '0;
               bus.cfg_ready <= 1'b1;
            end
            LOAD: if (bus.cfg_start) cnt <= '0;
            else if (accept) begin
               cnt <= last ? '0 : cnt + CW'(1);
               if (last) begin
                  state            <= RUN;
                  bus.cfg_ready    <= 1'b0;
                  bus.cfg_done     <= 1'b1;
                  bus.table_loaded <= 1'b1;
               end
            end
            RUN: if (bus.cfg_start) begin
               state            <= LOAD;
               cnt              <= '0;
               bus.cfg_ready    <= 1'b1;
               bus.table_loaded <= 1'b0;
            end
            default: state <= EMPTY;
         endcase
      end
   end
endmodule

// File: tb/tb_lut_neuron_loader.sv
// tb_lut_neuron_loader: random and directed loads/lookups checked against a bit-array model every cycle.
module tb_lut_neuron_loader;
   localparam int IB = 6, OB = 1, LW = 8, DEPTH = 64, BEATS = 8;
   logic clk = 0, rst = 1;
   int total = 0, bad = 0;
   lut_neuron_loader_if #(.IN_BITS(IB), .OUT_BITS(OB), .LOAD_WIDTH(LW)) bus();
   lut_neuron_loader #(.IN_BITS(IB), .OUT_BITS(OB), .LOAD_WIDTH(LW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: flat table bits plus loading/loaded flags
   bit armed = 0, m_loading = 0, m_loaded = 0, exp_done = 0, exp_valid = 0;
   logic [OB-1:0] exp_data = '0;
   bit model_bits [DEPTH*OB];
   int m_beats = 0;
   always @(posedge clk) begin
      if (rst) begin
         armed = 1; m_loading = 0; m_loaded = 0; m_beats = 0;
         exp_done = 0; exp_valid = 0; exp_data = '0;
      end else begin
         exp_done = 0;
         exp_valid = bus.in_valid && m_loaded;
         if (exp_valid) for (int b = 0; b < OB; b++) exp_data[b] = model_bits[int'(bus.in_data)*OB+b];
         if (bus.cfg_start) begin
            m_loading = 1; m_loaded = 0; m_beats = 0;
         end else if (m_loading && bus.cfg_valid) begin
            for (int j = 0; j < LW; j++) model_bits[m_beats*LW+j] = bus.cfg_data[j];
            m_beats++;
            if (m_beats == BEATS) begin m_loading = 0; m_loaded = 1; exp_done = 1; end
         end
      end
   end

   always @(negedge clk) if (armed) begin
      chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_loading));
      chk("cfg_done", 32'(bus.cfg_done), 32'(exp_done));
      chk("table_loaded", 32'(bus.table_loaded), 32'(m_loaded));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("out_data", 32'(bus.out_data), 32'(exp_data));
   end

   int cyc = 0, hs = 0, dn = 0, t_first = 0, t_done = 0;
   always @(posedge clk) begin
      cyc++;
      if (bus.cfg_valid && bus.cfg_ready) begin
         if (hs == 0) t_first = cyc;
         hs++;
      end
      if (bus.cfg_done) begin dn++; t_done = cyc; end
   end

   task automatic step(input bit s, input bit v, input logic [LW-1:0] d, input bit iv, input logic [IB-1:0] a);
      @(negedge clk);
      rst = 0;
      bus.cfg_start = s; bus.cfg_valid = v; bus.cfg_data = d; bus.in_valid = iv; bus.in_data = a;
   endtask

   task automatic look(input logic [IB-1:0] a, input logic [OB-1:0] e);
      step(0, 0, 0, 1, a);
      step(0, 0, 0, 0, 0);
      chk("look_valid", 32'(bus.out_valid), 1);
      chk("look_data", 32'(bus.out_data), 32'(e));
   endtask

   logic [LW-1:0] pat [BEATS] = '{8'hAA, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h81};

   task automatic load_pat(input bit gaps);
      hs = 0; dn = 0;
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < BEATS; k++) begin
         step(0, 1, pat[k], 0, 0);
         if (gaps) step(0, 0, 8'h33, 0, 0);
      end
      step(0, 1, 8'h55, 0, 0);
      step(0, 1, 8'h55, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("beats_accepted", hs, BEATS);
      chk("done_pulses", dn, 1);
      chk("loaded_after", 32'(bus.table_loaded), 1);
      look(6'h01, 1); look(6'h00, 0); look(6'h22, 1);
      look(6'h38, 1); look(6'h3F, 1); look(6'h3E, 0);
   endtask

   task automatic fill_and_read(input logic [LW-1:0] v);
      for (int k = 0; k < BEATS; k++) step(0, 1, v, 0, 0);
      step(0, 0, 0, 0, 0);
      for (int a = 0; a < DEPTH; a++) step(0, 0, 0, 1, 6'(a));
      step(0, 0, 0, 0, 0);
      chk("fill_last_data", 32'(bus.out_data), 32'(v[0]));
   endtask

   initial begin
      bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_data = 0; bus.in_valid = 0; bus.in_data = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(bus.cfg_ready), 0);
      chk("rst_done", 32'(bus.cfg_done), 0);
      chk("rst_loaded", 32'(bus.table_loaded), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      step(0, 0, 0, 1, 6'h20);
      step(0, 0, 0, 0, 0);
      chk("empty_lookup_dropped", 32'(bus.out_valid), 0);

      load_pat(0);
      load_pat(1);
      chk("gap_done_latency", t_done - t_first, 15);

      for (int a = 0; a < DEPTH; a++) begin
         step(0, 0, 0, 1, 6'(a));
         if (a > 0) chk("b2b_valid", 32'(bus.out_valid), 1);
      end
      step(0, 0, 0, 0, 0);
      chk("b2b_last", 32'(bus.out_data), 1);

      // restart after 3 beats, with a beat presented on the restart cycle
      dn = 0;
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 1, 8'($urandom), 0, 0);
      step(1, 1, 8'h00, 0, 0);
      fill_and_read(8'hFF);
      chk("restart_done", dn, 1);

      // reload from RUN with a restart coincident with the final beat
      dn = 0;
      step(1, 0, 0, 1, 6'h22);
      step(0, 0, 0, 1, 6'h05);
      chk("reload_loaded_low", 32'(bus.table_loaded), 0);
      chk("last_run_lookup", 32'(bus.out_valid), 1);
      step(0, 0, 0, 0, 0);
      chk("load_lookup_dropped", 32'(bus.out_valid), 0);
      for (int k = 0; k < BEATS-1; k++) step(0, 1, 8'h00, 0, 0);
      step(1, 1, 8'h00, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("coincident_no_done", dn, 0);
      chk("coincident_still_load", 32'(bus.cfg_ready), 1);
      fill_and_read(8'h00);
      chk("reload_done", dn, 1);

      // reset in the middle of a load
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) step(0, 1, 8'($urandom), 0, 0);
      @(negedge clk);
      rst = 1; bus.cfg_valid = 0; bus.cfg_start = 0;
      step(0, 0, 0, 1, 6'h10);
      chk("midrst_loaded", 32'(bus.table_loaded), 0);
      chk("midrst_ready", 32'(bus.cfg_ready), 0);
      step(0, 0, 0, 0, 0);
      chk("midrst_lookup_dropped", 32'(bus.out_valid), 0);

      // random loads and lookups, model-checked every cycle
      for (int r = 0; r < 4; r++) begin
         dn = 0;
         step(1, 0, 0, 0, 0);
         for (int i = 0; i < 300 && dn == 0; i++)
            step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 6'($urandom));
         chk("rand_load_done", dn, 1);
         for (int i = 0; i < 100; i++)
            step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 6'($urandom));
      end
      step(0, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
